// File: rtl/irq_ctrl.sv
// irq_ctrl: per-channel polarity normalise, synchronise, glitch filter, edge/level detect,
//           sticky pending with software set/clear, masked per-channel and summary outputs.
// Latency:  irq_in_i to status_o/pending_o = SYNC+FILT edges; intr_o/irq_any_o one edge later.
// Backpressure: none; pending bits hold events until software clears them.
//
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   irq_in_i        raw asynchronous interrupt pins
//   pol_i           1 = pin is active-low (change only while the channel is masked)
//   edge_i          1 = edge mode (inactive->active), 0 = level mode
//   mask_i          1 = channel forwarded to intr_o / irq_any_o
//   set_i, clr_i    single-cycle software set / write-1-to-clear of pending
//   status_o        filtered active level
//   pending_o       sticky pending flags
//   intr_o          registered pending & mask
//   irq_any_o       registered OR of pending & mask
module irq_ctrl #(
   parameter int NIRQ = 4,
   parameter int SYNC = 2,
   parameter int FILT = 3
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic [NIRQ-1:0] irq_in_i,
   input  logic [NIRQ-1:0] pol_i,
   input  logic [NIRQ-1:0] edge_i,
   input  logic [NIRQ-1:0] mask_i,
   input  logic [NIRQ-1:0] set_i,
   input  logic [NIRQ-1:0] clr_i,
   output logic [NIRQ-1:0] status_o,
   output logic [NIRQ-1:0] pending_o,
   output logic [NIRQ-1:0] intr_o,
   output logic            irq_any_o
);

   localparam int CW = $clog2(FILT + 1);
   localparam logic [CW-1:0] CNT_LAST = CW'(FILT - 1);
   localparam logic [CW-1:0] CNT_ONE  = CW'(1);

   logic [NIRQ-1:0] act;
   logic [NIRQ-1:0] sync_q [SYNC];
   logic [NIRQ-1:0] s;
   logic [CW-1:0]   cnt_q [NIRQ];
   logic [CW-1:0]   cnt_d [NIRQ];
   logic [NIRQ-1:0] status_q, status_d;
   logic [NIRQ-1:0] pending_q, pending_d;
   logic [NIRQ-1:0] evt;
   logic [NIRQ-1:0] intr_q;
   logic            irq_any_q;

   // Normalise before the first flop so that the reset value 0 means inactive.
   assign act = irq_in_i ^ pol_i;
   assign s   = sync_q[SYNC-1];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int k = 0; k < SYNC; k++) begin
            sync_q[k] <= '0;
         end
      end else begin
         sync_q[0] <= act;
         for (int k = 1; k < SYNC; k++) begin
            sync_q[k] <= sync_q[k-1];
         end
      end
   end

   // Filter: the counter tracks consecutive samples where s disagrees with status;
   // the FILT-th disagreeing sample is accepted as the new level.
   always_comb begin
      status_d = status_q;
      for (int i = 0; i < NIRQ; i++) begin
         cnt_d[i] = cnt_q[i];
         if (s[i] == status_q[i]) begin
            cnt_d[i] = '0;
         end else if (cnt_q[i] == CNT_LAST) begin
            status_d[i] = s[i];
            cnt_d[i]    = '0;
         end else begin
            cnt_d[i] = cnt_q[i] + CNT_ONE;
         end
      end
   end

   // Events come from the value being loaded, so they land in pending on the
   // same edge that status changes. Event/set beat clr on a collision.
   always_comb begin
      evt       = (edge_i & status_d & ~status_q) | (~edge_i & status_d);
      pending_d = (pending_q & ~clr_i) | evt | set_i;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NIRQ; i++) begin
            cnt_q[i] <= '0;
         end
         status_q  <= '0;
         pending_q <= '0;
         intr_q    <= '0;
         irq_any_q <= 1'b0;
      end else begin
         for (int i = 0; i < NIRQ; i++) begin
            cnt_q[i] <= cnt_d[i];
         end
         status_q  <= status_d;
         pending_q <= pending_d;
         intr_q    <= pending_q & mask_i;
         irq_any_q <= |(pending_q & mask_i);
      end
   end

   assign status_o  = status_q;
   assign pending_o = pending_q;
   assign intr_o    = intr_q;
   assign irq_any_o = irq_any_q;

endmodule

// File: tb/tb_irq_ctrl.sv
// tb_irq_ctrl: directed scenarios plus randomised traffic against a window-based reference model.
// Latency:  outputs sampled on the falling edge after each rising edge.
// Backpressure: not applicable.
module tb_irq_ctrl;

   localparam int N  = 4;
   localparam int SY = 2;
   localparam int FI = 3;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic [N-1:0] irq_in = '0;
   logic [N-1:0] pol = '0;
   logic [N-1:0] edge_m = '0;
   logic [N-1:0] mask = '0;
   logic [N-1:0] set_p = '0;
   logic [N-1:0] clr_p = '0;
   logic [N-1:0] status, pending, intr;
   logic         irq_any;

   int compared   = 0;
   int mismatched = 0;

   always #5 clk = ~clk;

   irq_ctrl #(.NIRQ(N), .SYNC(SY), .FILT(FI)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .irq_in_i  (irq_in),
      .pol_i     (pol),
      .edge_i    (edge_m),
      .mask_i    (mask),
      .set_i     (set_p),
      .clr_i     (clr_p),
      .status_o  (status),
      .pending_o (pending),
      .intr_o    (intr),
      .irq_any_o (irq_any)
   );

   // Reference model: a delay line of SY samples, then a level is accepted once
   // the last FI delayed samples all disagree with the current accepted level.
   logic [N-1:0] m_sync [$];
   logic [N-1:0] m_win  [$];
   logic [N-1:0] m_status, m_pending, m_intr;
   logic         m_any;

   always @(posedge clk or negedge rst_n) begin : mdl
      logic [N-1:0] s_now, st_n, ev;
      bit all_diff;
      if (!rst_n) begin
         m_sync.delete();
         for (int k = 0; k < SY; k++) m_sync.push_back('0);
         m_win.delete();
         m_status  = '0;
         m_pending = '0;
         m_intr    = '0;
         m_any     = 1'b0;
      end else begin
         s_now = m_sync.pop_front();
         m_sync.push_back(irq_in ^ pol);
         m_win.push_back(s_now);
         if (m_win.size() > FI) void'(m_win.pop_front());
         st_n = m_status;
         if (m_win.size() == FI) begin
            for (int ch = 0; ch < N; ch++) begin
               all_diff = 1'b1;
               foreach (m_win[j]) if (m_win[j][ch] == m_status[ch]) all_diff = 1'b0;
               if (all_diff) st_n[ch] = ~m_status[ch];
            end
         end
         for (int ch = 0; ch < N; ch++)
            ev[ch] = edge_m[ch] ? (st_n[ch] && !m_status[ch]) : st_n[ch];
         m_intr    = m_pending & mask;
         m_any     = |(m_pending & mask);
         m_pending = (m_pending & ~clr_p) | ev | set_p;
         m_status  = st_n;
      end
   end

   function automatic logic [3*N:0] dut_vec();
      return {status, pending, intr, irq_any};
   endfunction

   function automatic logic [3*N:0] mdl_vec();
      return {m_status, m_pending, m_intr, m_any};
   endfunction

   task automatic test_reset();
      rst_n  = 1'b0;
      irq_in = 4'hF;
      pol    = 4'hF;
      mask   = 4'hF;
      repeat (3) @(negedge clk);
      compared++;
      if (dut_vec() !== '0) begin
         mismatched++;
         $display("FAIL reset_state got %b want 0", dut_vec());
      end
      rst_n = 1'b1;
      for (int c = 0; c < 50; c++) begin
         @(negedge clk);
         compared++;
         if (dut_vec() !== '0) begin
            mismatched++;
            $display("FAIL reset_quiet cyc=%0d got %b want 0", c, dut_vec());
         end
      end
   endtask

   task automatic test_level();
      int pend_cnt;
      @(negedge clk);
      pol    = 4'b0100;
      irq_in = 4'b0100;
      edge_m = 4'b0100;
      mask   = 4'b0111;
      repeat (10) @(negedge clk);
      irq_in[0] = 1'b1;
      for (int k = 1; k <= 6; k++) begin
         @(negedge clk);
         compared++;
         if ({status[0], pending[0], intr[0], irq_any} !==
             {k >= 5, k >= 5, k >= 6, k >= 6}) begin
            mismatched++;
            $display("FAIL level_rise edge=%0d got %b want %b", k,
                     {status[0], pending[0], intr[0], irq_any},
                     {k >= 5, k >= 5, k >= 6, k >= 6});
         end
      end
      clr_p[0] = 1'b1;
      @(negedge clk);
      clr_p[0] = 1'b0;
      compared++;
      if (pending[0] !== 1'b1) begin
         mismatched++;
         $display("FAIL level_clr_held got %b want 1", pending[0]);
      end
      irq_in[0] = 1'b0;
      repeat (6) @(negedge clk);
      clr_p[0] = 1'b1;
      @(negedge clk);
      clr_p[0] = 1'b0;
      compared++;
      if ({pending[0], intr[0]} !== 2'b01) begin
         mismatched++;
         $display("FAIL level_clr_pend got %b want 01", {pending[0], intr[0]});
      end
      @(negedge clk);
      compared++;
      if ({intr[0], irq_any} !== 2'b00) begin
         mismatched++;
         $display("FAIL level_clr_intr got %b want 00", {intr[0], irq_any});
      end
      pend_cnt = 0;
      compared++;
      if (dut_vec() !== mdl_vec()) begin
         mismatched++;
         $display("FAIL level_model got %b want %b", dut_vec(), mdl_vec());
      end
   endtask

   task automatic test_glitch();
      int hi;
      irq_in[1] = 1'b1;
      repeat (2) @(negedge clk);
      irq_in[1] = 1'b0;
      hi = 0;
      for (int c = 0; c < 12; c++) begin
         @(negedge clk);
         if (status[1] || pending[1] || intr[1]) hi++;
      end
      compared++;
      if (hi != 0) begin
         mismatched++;
         $display("FAIL glitch_short cycles_active=%0d want 0", hi);
      end
      irq_in[1] = 1'b1;
      repeat (3) @(negedge clk);
      irq_in[1] = 1'b0;
      hi = 0;
      for (int c = 0; c < 15; c++) begin
         @(negedge clk);
         if (status[1]) hi++;
      end
      compared++;
      if (hi != 3) begin
         mismatched++;
         $display("FAIL glitch_accept status_cycles=%0d want 3", hi);
      end
      compared++;
      if (pending[1] !== 1'b1) begin
         mismatched++;
         $display("FAIL glitch_pending got %b want 1", pending[1]);
      end
      clr_p[1] = 1'b1;
      @(negedge clk);
      clr_p[1] = 1'b0;
      compared++;
      if (pending[1] !== 1'b0) begin
         mismatched++;
         $display("FAIL glitch_clr got %b want 0", pending[1]);
      end
   endtask

   task automatic test_edge();
      int rises, ones;
      logic prev;
      irq_in[2] = 1'b0;
      rises = 0;
      ones  = 0;
      prev  = 1'b0;
      for (int c = 1; c <= 100; c++) begin
         @(negedge clk);
         if (c < 21) begin
            if (pending[2] && !prev) rises++;
            prev = pending[2];
         end else if (pending[2]) begin
            ones++;
         end
         clr_p[2] = (c == 20);
      end
      compared++;
      if (rises != 1) begin
         mismatched++;
         $display("FAIL edge_once rises=%0d want 1", rises);
      end
      compared++;
      if (ones != 0) begin
         mismatched++;
         $display("FAIL edge_after_clr pending_cycles=%0d want 0", ones);
      end
      irq_in[2] = 1'b1;
      repeat (10) @(negedge clk);
      irq_in[2] = 1'b0;
      for (int k = 1; k <= 5; k++) begin
         @(negedge clk);
         if (k >= 4) begin
            compared++;
            if (pending[2] !== (k == 5)) begin
               mismatched++;
               $display("FAIL edge_second edge=%0d got %b want %b", k, pending[2], k == 5);
            end
         end
      end
      clr_p[2] = 1'b1;
      @(negedge clk);
      clr_p[2] = 1'b0;
   endtask

   task automatic test_mask();
      irq_in[3] = 1'b1;
      repeat (4) @(negedge clk);
      irq_in[3] = 1'b0;
      repeat (12) @(negedge clk);
      compared++;
      if ({pending[3], intr[3], irq_any} !== 3'b100) begin
         mismatched++;
         $display("FAIL mask_off got %b want 100", {pending[3], intr[3], irq_any});
      end
      mask[3] = 1'b1;
      @(negedge clk);
      compared++;
      if ({intr[3], irq_any} !== 2'b11) begin
         mismatched++;
         $display("FAIL mask_on got %b want 11", {intr[3], irq_any});
      end
      set_p[3] = 1'b1;
      clr_p[3] = 1'b1;
      @(negedge clk);
      set_p[3] = 1'b0;
      @(negedge clk);
      clr_p[3] = 1'b0;
      compared++;
      if (pending[3] !== 1'b0) begin
         mismatched++;
         $display("FAIL mask_clr got %b want 0", pending[3]);
      end
      set_p[3] = 1'b1;
      clr_p[3] = 1'b1;
      @(negedge clk);
      set_p[3] = 1'b0;
      clr_p[3] = 1'b0;
      compared++;
      if (pending[3] !== 1'b1) begin
         mismatched++;
         $display("FAIL mask_set_clr got %b want 1", pending[3]);
      end
      compared++;
      if (dut_vec() !== mdl_vec()) begin
         mismatched++;
         $display("FAIL mask_model got %b want %b", dut_vec(), mdl_vec());
      end
   endtask

   task automatic test_random();
      for (int c = 0; c < 2000; c++) begin
         @(negedge clk);
         compared++;
         if (dut_vec() !== mdl_vec()) begin
            mismatched++;
            $display("FAIL random cyc=%0d got %b want %b", c, dut_vec(), mdl_vec());
         end
         for (int i = 0; i < N; i++)
            if ($urandom_range(3) == 0) irq_in[i] = ~irq_in[i];
         set_p = ($urandom_range(15) == 0) ? N'($urandom) : '0;
         clr_p = ($urandom_range(7) == 0) ? N'($urandom) : '0;
         if ($urandom_range(49) == 0) edge_m = N'($urandom);
         if ($urandom_range(29) == 0) mask = N'($urandom);
      end
      set_p = '0;
      clr_p = '0;
   endtask

   task automatic test_reset_mid();
      @(negedge clk);
      rst_n  = 1'b0;
      irq_in = '0;
      pol    = '0;
      edge_m = '0;
      mask   = 4'hF;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (5) @(negedge clk);
      irq_in[0] = 1'b1;
      repeat (2) @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      compared++;
      if (dut_vec() !== '0) begin
         mismatched++;
         $display("FAIL reset_mid_clear got %b want 0", dut_vec());
      end
      @(negedge clk);
      rst_n = 1'b1;
      for (int k = 1; k <= SY + FI; k++) begin
         @(negedge clk);
         compared++;
         if (status[0] !== (k >= SY + FI)) begin
            mismatched++;
            $display("FAIL reset_mid_relatch edge=%0d got %b want %b", k, status[0], k >= SY + FI);
         end
      end
      compared++;
      if (dut_vec() !== mdl_vec()) begin
         mismatched++;
         $display("FAIL reset_mid_model got %b want %b", dut_vec(), mdl_vec());
      end
   endtask

   initial begin
      test_reset();
      test_level();
      test_glitch();
      test_edge();
      test_mask();
      test_random();
      test_reset_mid();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule

// File: doc/irq_ctrl.md
Name: irq_ctrl

Overview:
Parametrised interrupt concentrator that replaces the fixed per-line delay/invert interrupt path in front of the CPU interrupt inputs. Each of NIRQ asynchronous interrupt sources passes through five stages: polarity normalisation, a multi-stage synchroniser, and a glitch filter, then a per-channel edge/level detector and a sticky pending register with software set/clear. Masked pending bits drive the per-channel CPU interrupt lines and a combined summary line. The block sits between board-level interrupt pins (RTC, temperature sensors, PPS, PLL events) and the register file/CPU.

Parameters:
NIRQ, 4, number of interrupt channels (1..32)
SYNC, 2, synchroniser stages per channel (>=2)
FILT, 3, consecutive stable samples required to accept a level change (1..15)

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
irq_in  in  NIRQ  raw asynchronous interrupt inputs
pol  in  NIRQ  per-channel polarity, quasi-static: 1 = active-low, 0 = active-high
edge  in  NIRQ  per-channel mode: 1 = edge (inactive->active), 0 = level
mask  in  NIRQ  per-channel enable: 1 = forwarded to intr
set  in  NIRQ  1-cycle software set of pending
clr  in  NIRQ  1-cycle write-1-to-clear of pending
status  out  NIRQ  filtered active level, after normalisation
pending  out  NIRQ  sticky pending flags
intr  out  NIRQ  registered pending & mask
irq_any  out  1  registered OR of pending & mask

Behaviour:
- One clock, clk. Reset is asynchronous and active-low on rst_n. Every flop clears to 0 on reset: synchroniser, filter counters, status, pending, intr, irq_any. Reset asserted mid-operation discards all in-flight events.
- Normalise: a = irq_in ^ pol, computed combinationally before the first synchroniser flop. 1 always means active. The synchroniser reset value of 0 is therefore the inactive state.
- Synchroniser: SYNC flops in series. The output s is valid after SYNC edges.
- Filter, per channel: a counter of width clog2(FILT+1).
  - If s == status: counter <= 0.
  - Otherwise, when counter == FILT-1: status <= s and counter <= 0.
  - Otherwise: counter++.
  - FILT=1 gives no filtering; status follows s one edge later.
  - Any pulse shorter than FILT samples at s is rejected.
- Event, computed from status_next (the value being loaded into status):
  - edge=1: event = status_next & ~status.
  - edge=0: event = status_next.
- Pending: pending <= (pending & ~clr) | event | set.
  - Event or set on the same edge as clr wins, so the bit stays 1.
  - In level mode, clr while the source is still active does not clear the bit; it re-asserts on the same edge.
- Latency: irq_in to status/pending = SYNC+FILT edges; intr and irq_any follow one edge later.
- intr <= pending & mask; irq_any <= |(pending & mask). Both are registered from the current pending.
- Masked channels still update status and pending. Unmasking a pending channel raises intr on the next edge.
- Changing edge or mask takes effect on the next edge and never modifies pending. pol must only change while the channel is masked; a spurious event caused by a pol change is then cleared by software.
- Widths: all per-channel vectors are NIRQ bits; bit i is channel i throughout.

Test Plan:
(NIRQ=4, SYNC=2, FILT=3; edge numbers count from the first edge after the stimulus change.)
- Reset: hold rst_n=0 with irq_in=4'hF and pol=4'hF. Then status=pending=intr=0 and irq_any=0. After release, with irq_in held, all outputs stay 0 for 50 cycles.
- Level mode, ch0 (pol=0, edge=0, mask=1): irq_in[0] 0->1 and held. Then status[0]=pending[0]=1 after edge 5; intr[0]=irq_any=1 after edge 6. A clr[0] pulse while held leaves pending[0]=1. Drop irq_in[0], wait 6 cycles, pulse clr[0]: pending[0]=0 and intr[0]=0 one edge later.
- Glitch, ch1 (pol=0): 2-cycle high pulse on irq_in[1] gives status/pending/intr[1]=0 throughout. A 3-cycle pulse gives status[1]=1 for exactly 3 cycles and pending[1]=1.
- Edge mode, ch2 (pol=1, edge=1, mask=1): irq_in[2] 1->0 held for 100 cycles. pending[2] sets once. clr at cycle 20 leaves pending[2]=0 for the rest of the hold. Release, then a second 1->0 transition sets pending[2] again after 5 edges.
- Mask and simultaneity, ch3 (mask=0): an event gives pending[3]=1 with intr[3]=0 and irq_any=0. Setting mask[3]=1 gives intr[3]=irq_any=1 one edge later. clr[3] and set[3] on the same edge leave pending[3]=1.
- Reset mid-event: assert rst_n=0 two cycles after irq_in[0] rises (before status sets). All outputs go to 0 immediately. After release, with the input held, status[0] sets SYNC+FILT edges later.
